fsm_turnos_param: RTL and testbench

Parametrised turn-based game controller for N players on the lab board game (gato and larger variants).
- Sequences player turns and enforces a per-turn timeout with an internal counter.
- Accepts moves through a valid/ok strobe pair and issues a one-cycle board-write strobe.
- Samples the external board evaluator, then declares a win or draw.
- Keeps saturating per-player win counts.
- Sits between the input/keypad decoder and board RAM/evaluator, with the VGA and Arduino blocks downstream.

---
 rtl/fsm_turnos_param.sv | 180 ++++++++++++++++++
 tb/tb_fsm_turnos_param.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fsm_turnos_param.sv
// Turn sequencer for an N-player board game: per-turn timeout, move accept/reject, win/draw and scores.
// Optional FSM_TURNOS_PERDEDOR_INICIA_EN: a new game opens with the player after the last winner.
module fsm_turnos_param #(
    parameter int NUM_JUG     = 2,
    parameter int TURN_CYCLES = 50000000,
    parameter int SCORE_W     = 4,
    localparam int JW         = (NUM_JUG > 2) ? $clog2(NUM_JUG) : 1,
    localparam int TW         = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic [1:0]                 modo,
    input  logic                       start,
    input  logic                       mov_valid,
    input  logic                       mov_ok,
    input  logic                       gano,
    input  logic                       lleno,
    output logic [JW-1:0]              jug,
    output logic                       escribir,
    output logic [JW:0]                ganador,
    output logic                       empate,
    output logic                       rand_req,
    output logic                       timeout,
    output logic                       mov_err,
    output logic                       reiniciar,
    output logic [NUM_JUG*SCORE_W-1:0] puntaje,
    output logic [2:0]                 estado
);

    typedef enum logic [1:0] {IDLE = 2'd0, TURNO = 2'd1, VERIFICA = 2'd2, FIN = 2'd3} state_t;

    state_t                     state, state_d;
    logic [TW-1:0]              timer, timer_d;
    logic [JW-1:0]              jug_d, jug_inicio;
    logic [JW:0]                ganador_d;
    logic                       empate_d, escribir_d, timeout_d, mov_err_d, reiniciar_d;
    logic [NUM_JUG*SCORE_W-1:0] puntaje_d;
    logic                       mov_acc, expira, abortar;

    // Wraps explicitly so non-power-of-2 player counts never reach an unused index.
    function automatic logic [JW-1:0] sig_jug(input logic [JW-1:0] j);
        return (j == JW'(NUM_JUG - 1)) ? '0 : j + 1'b1;
    endfunction

    assign mov_acc = mov_valid && mov_ok;
    assign expira  = (timer == TW'(TURN_CYCLES - 1));
    assign abortar = (state != IDLE) && (modo == 2'd0);

`ifdef FSM_TURNOS_PERDEDOR_INICIA_EN
    logic [JW:0] ultimo, ultimo_d;

    always_comb begin
        ultimo_d = ultimo;
        if (state == VERIFICA && !abortar) begin
            if (gano)
                ultimo_d = {1'b0, jug} + 1'b1;
            else if (lleno)
                ultimo_d = '0;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)
            ultimo <= '0;
        else
            ultimo <= ultimo_d;
    end

    assign jug_inicio = (ultimo != '0) ? sig_jug(JW'(ultimo - 1'b1)) : '0;
`else
    assign jug_inicio = '0;
`endif

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:     if (start && modo != 2'd0) state_d = TURNO;
            TURNO:    if (mov_acc) state_d = VERIFICA;
            VERIFICA: state_d = (gano || lleno) ? FIN : TURNO;
            FIN:      if (start) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (abortar)
            state_d = IDLE;
    end

    always_comb begin
        jug_d       = jug;
        timer_d     = timer;
        ganador_d   = ganador;
        empate_d    = empate;
        puntaje_d   = puntaje;
        escribir_d  = 1'b0;
        timeout_d   = 1'b0;
        mov_err_d   = 1'b0;
        reiniciar_d = 1'b0;
        if (abortar) begin
            reiniciar_d = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start && modo != 2'd0) begin
                        jug_d       = jug_inicio;
                        timer_d     = '0;
                        ganador_d   = '0;
                        empate_d    = 1'b0;
                        reiniciar_d = 1'b1;
                    end
                end
                TURNO: begin
                    timer_d = timer + 1'b1;
                    if (mov_acc) begin
                        escribir_d = 1'b1;
                    end else begin
                        mov_err_d = mov_valid;
                        if (expira) begin
                            timeout_d = 1'b1;
                            jug_d     = sig_jug(jug);
                            timer_d   = '0;
                        end
                    end
                end
                VERIFICA: begin
                    if (gano) begin
                        ganador_d = {1'b0, jug} + 1'b1;
                        for (int i = 0; i < NUM_JUG; i++) begin
                            if (i == int'(jug) && puntaje[i*SCORE_W +: SCORE_W] != '1)
                                puntaje_d[i*SCORE_W +: SCORE_W] = puntaje[i*SCORE_W +: SCORE_W] + 1'b1;
                        end
                    end else if (lleno) begin
                        empate_d = 1'b1;
                    end else begin
                        jug_d   = sig_jug(jug);
                        timer_d = '0;
                    end
                end
                FIN: begin
                    if (start)
                        reiniciar_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            jug       <= '0;
            timer     <= '0;
            ganador   <= '0;
            empate    <= 1'b0;
            puntaje   <= '0;
            escribir  <= 1'b0;
            timeout   <= 1'b0;
            mov_err   <= 1'b0;
            reiniciar <= 1'b0;
        end else begin
            jug       <= jug_d;
            timer     <= timer_d;
            ganador   <= ganador_d;
            empate    <= empate_d;
            puntaje   <= puntaje_d;
            escribir  <= escribir_d;
            timeout   <= timeout_d;
            mov_err   <= mov_err_d;
            reiniciar <= reiniciar_d;
        end
    end

    assign rand_req = (state == TURNO) && (modo == 2'd2) && (jug == JW'(NUM_JUG - 1));
    assign estado   = {1'b0, state};

endmodule

// File: tb/tb_fsm_turnos_param.sv
// Directed bench: 2-player and 3-player instances, both with an 8-cycle turn limit.
module tb_fsm_turnos_param;

    logic       clk = 1'b0;
    logic       Reset;
    logic [1:0] modo, modo3;
    logic       start, mov_valid, mov_ok, gano, lleno;
    logic       start3, mov_valid3, mov_ok3, gano3, lleno3;

    logic       jug, escribir, empate, rand_req, timeout, mov_err, reiniciar;
    logic [1:0] ganador;
    logic [7:0] puntaje;
    logic [2:0] estado;

    logic [1:0]  jug3, ganador3;
    logic        escribir3, empate3, rand_req3, timeout3, mov_err3, reiniciar3;
    logic [11:0] puntaje3;
    logic [2:0]  estado3;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fsm_turnos_param #(.NUM_JUG(2), .TURN_CYCLES(8), .SCORE_W(4)) dut2 (
        .clk(clk), .Reset(Reset), .modo(modo), .start(start),
        .mov_valid(mov_valid), .mov_ok(mov_ok), .gano(gano), .lleno(lleno),
        .jug(jug), .escribir(escribir), .ganador(ganador), .empate(empate),
        .rand_req(rand_req), .timeout(timeout), .mov_err(mov_err),
        .reiniciar(reiniciar), .puntaje(puntaje), .estado(estado)
    );

    fsm_turnos_param #(.NUM_JUG(3), .TURN_CYCLES(8), .SCORE_W(4)) dut3 (
        .clk(clk), .Reset(Reset), .modo(modo3), .start(start3),
        .mov_valid(mov_valid3), .mov_ok(mov_ok3), .gano(gano3), .lleno(lleno3),
        .jug(jug3), .escribir(escribir3), .ganador(ganador3), .empate(empate3),
        .rand_req(rand_req3), .timeout(timeout3), .mov_err(mov_err3),
        .reiniciar(reiniciar3), .puntaje(puntaje3), .estado(estado3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Player 0 makes a non-winning move so player 1 is on turn, then player 1 wins.
    task automatic gana_jug1();
        mov_valid = 1; mov_ok = 1; step();
        mov_valid = 0; mov_ok = 0; step();
        mov_valid = 1; mov_ok = 1; step();
        mov_valid = 0; mov_ok = 0; gano = 1; step();
        gano = 0;
    endtask

    initial begin
        Reset = 1; modo = 0; start = 0; mov_valid = 0; mov_ok = 0; gano = 0; lleno = 0;
        modo3 = 0; start3 = 0; mov_valid3 = 0; mov_ok3 = 0; gano3 = 0; lleno3 = 0;
        step(); step();
        chk("rst_estado", estado, 0);
        chk("rst_jug", jug, 0);
        chk("rst_ganador", ganador, 0);
        chk("rst_empate", empate, 0);
        chk("rst_puntaje", puntaje, 0);
        chk("rst_pulses", {escribir, timeout, mov_err, reiniciar}, 0);
        chk("rst_estado3", estado3, 0);
        Reset = 0;

        // Start game
        modo = 1; start = 1; step();
        chk("start_estado", estado, 1);
        chk("start_reiniciar", reiniciar, 1);
        chk("start_jug", jug, 0);
        start = 0; step();
        chk("start_reiniciar_off", reiniciar, 0);

        // Accepted move, no result
        mov_valid = 1; mov_ok = 1; step();
        chk("acc_escribir", escribir, 1);
        chk("acc_estado", estado, 2);
        mov_valid = 0; mov_ok = 0; step();
        chk("ver_estado", estado, 1);
        chk("ver_jug", jug, 1);
        chk("ver_escribir_off", escribir, 0);

        // Timeout after 8 idle cycles
        for (int i = 0; i < 7; i++) begin
            step();
            chk("to_quiet", timeout, 0);
        end
        step();
        chk("to_pulse", timeout, 1);
        chk("to_jug", jug, 0);
        step();
        chk("to_pulse_off", timeout, 0);

        // Accepted move on the expiry cycle beats the timeout
        for (int i = 0; i < 6; i++) step();
        mov_valid = 1; mov_ok = 1; step();
        chk("exp_move_timeout", timeout, 0);
        chk("exp_move_escribir", escribir, 1);
        chk("exp_move_estado", estado, 2);
        mov_valid = 0; mov_ok = 0; step();
        chk("exp_move_jug", jug, 1);

        // Rejected move
        mov_valid = 1; mov_ok = 0; step();
        chk("err_pulse", mov_err, 1);
        chk("err_escribir", escribir, 0);
        chk("err_jug", jug, 1);
        chk("err_estado", estado, 1);
        mov_valid = 0; step();
        chk("err_pulse_off", mov_err, 0);

        // Player 1 wins
        mov_valid = 1; mov_ok = 1; step();
        mov_valid = 0; mov_ok = 0; gano = 1; step();
        gano = 0;
        chk("win_estado", estado, 3);
        chk("win_ganador", ganador, 2);
        chk("win_puntaje", puntaje, 8'h10);
        step();
        chk("win_hold_ganador", ganador, 2);
        chk("win_hold_estado", estado, 3);

        // Restart with start held through IDLE, then 16 more wins for player 1
        for (int k = 1; k <= 16; k++) begin
            start = 1; step();
            if (k == 1) begin
                chk("fin_idle_estado", estado, 0);
                chk("fin_idle_reiniciar", reiniciar, 1);
            end
            step();
            if (k == 1) begin
                chk("restart_estado", estado, 1);
                chk("restart_ganador", ganador, 0);
                chk("restart_jug", jug, 0);
            end
            start = 0;
            gana_jug1();
            chk("sat_puntaje", puntaje[7:4], (k + 1 > 15) ? 15 : k + 1);
        end
        chk("sat_final", puntaje, 8'hF0);

        // Draw
        start = 1; step(); step(); start = 0;
        mov_valid = 1; mov_ok = 1; step();
        mov_valid = 0; mov_ok = 0; lleno = 1; step();
        lleno = 0;
        chk("draw_estado", estado, 3);
        chk("draw_empate", empate, 1);
        chk("draw_ganador", ganador, 0);
        chk("draw_puntaje", puntaje, 8'hF0);

        // gano and lleno together count as a win for player 0
        start = 1; step(); step(); start = 0;
        chk("newgame_empate", empate, 0);
        mov_valid = 1; mov_ok = 1; step();
        mov_valid = 0; mov_ok = 0; gano = 1; lleno = 1; step();
        gano = 0; lleno = 0;
        chk("both_ganador", ganador, 1);
        chk("both_empate", empate, 0);
        chk("both_puntaje", puntaje, 8'hF1);

        // 3 players, player 2 is CPU
        modo3 = 2; start3 = 1; step();
        start3 = 0;
        chk("p3_estado", estado3, 1);
        chk("p3_jug", jug3, 0);
        chk("p3_rand0", rand_req3, 0);
        for (int t = 1; t <= 3; t++) begin
            for (int i = 0; i < 7; i++) step();
            chk("p3_to_quiet", timeout3, 0);
            step();
            chk("p3_to_pulse", timeout3, 1);
            chk("p3_jug_seq", jug3, t % 3);
            chk("p3_rand", rand_req3, (t % 3 == 2) ? 1 : 0);
        end

        // modo forced to 0 mid-turn
        step(); step();
        modo3 = 0; step();
        chk("p3_abort_estado", estado3, 0);
        chk("p3_abort_reiniciar", reiniciar3, 1);
        chk("p3_abort_rand", rand_req3, 0);
        step();
        chk("p3_abort_reiniciar_off", reiniciar3, 0);

        // Asynchronous reset mid-game clears scores without a clock edge
        start = 1; step(); step(); start = 0;
        chk("pre_rst_estado", estado, 1);
        #2 Reset = 1; #1;
        chk("async_rst_estado", estado, 0);
        chk("async_rst_puntaje", puntaje, 0);
        step();
        Reset = 0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
